lfsr_result_sequencer: RTL and testbench

LFSR_RESULT_SEQUENCER -- requirements
Module: lfsr_result_sequencer

---
 rtl/lfsr_result_sequencer.sv | 157 +++++++++++++++
 tb/tb_lfsr_result_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_result_sequencer.sv
// Sequencer that requests numbered results from an external pseudo-random
// generator, converts each result to BCD serially and emits it with a hold gap.
module lfsr_result_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int HOLD    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go,
  input  logic [7:0]  last_seq,
  output logic        gen_start,
  output logic [7:0]  gen_seq_num,
  input  logic        gen_busy,
  input  logic [7:0]  gen_num,
  output logic [7:0]  result,
  output logic [11:0] bcd,
  output logic        result_valid,
  output logic        running,
  output logic        timeout_err
);

  localparam int CNT_MAX = (TIMEOUT > HOLD) ? TIMEOUT : HOLD;
  localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_BUSY,
    WAIT_DONE,
    CONVERT,
    EMIT,
    HOLD_ST
  } state_t;

  state_t         state;
  logic [7:0]     seq_idx;
  logic [7:0]     last_cap;
  logic [7:0]     cap;
  logic [19:0]    work;
  logic [19:0]    work_next;
  logic [2:0]     bit_cnt;
  logic [CW-1:0]  cnt;

  // One shift-add-3 step on {hundreds, tens, ones, binary}: correct each
  // BCD digit that would overflow on doubling, then shift the whole word left.
  function automatic logic [19:0] bcd_step(input logic [19:0] w);
    logic [19:0] a;
    a = w;
    for (int d = 0; d < 3; d++) begin
      if (a[8+4*d +: 4] >= 4'd5) a[8+4*d +: 4] = a[8+4*d +: 4] + 4'd3;
    end
    return {a[18:0], 1'b0};
  endfunction

  assign work_next = bcd_step(work);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      gen_start    <= 1'b0;
      gen_seq_num  <= 8'd0;
      result       <= 8'd0;
      bcd          <= 12'd0;
      result_valid <= 1'b0;
      running      <= 1'b0;
      timeout_err  <= 1'b0;
      seq_idx      <= 8'd0;
      last_cap     <= 8'd0;
      cap          <= 8'd0;
      work         <= 20'd0;
      bit_cnt      <= 3'd0;
      cnt          <= '0;
    end else begin
      // NOTE: pulse outputs default low every cycle with non-blocking
      // assignments; the state that wants a pulse overrides it below.
      gen_start    <= 1'b0;
      result_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (go) begin
            last_cap    <= last_seq;
            seq_idx     <= 8'd0;
            gen_seq_num <= 8'd0;
            timeout_err <= 1'b0;
            running     <= 1'b1;
            gen_start   <= 1'b1;
            state       <= REQ;
          end
        end

        REQ: begin
          cnt   <= '0;
          state <= WAIT_BUSY;
        end

        WAIT_BUSY: begin
          if (gen_busy) begin
            state <= WAIT_DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            running     <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WAIT_DONE: begin
          if (!gen_busy) begin
            cap     <= gen_num;
            work    <= {12'd0, gen_num};
            bit_cnt <= 3'd0;
            state   <= CONVERT;
          end
        end

        CONVERT: begin
          work    <= work_next;
          bit_cnt <= bit_cnt + 3'd1;
          // The eighth step lands directly in the output registers so that
          // result, bcd and result_valid all appear in the EMIT cycle.
          if (bit_cnt == 3'd7) begin
            result       <= cap;
            bcd          <= work_next[19:8];
            result_valid <= 1'b1;
            state        <= EMIT;
          end
        end

        EMIT: begin
          cnt   <= '0;
          state <= HOLD_ST;
        end

        HOLD_ST: begin
          if (cnt == CW'(HOLD - 1)) begin
            if (seq_idx == last_cap) begin
              running <= 1'b0;
              state   <= IDLE;
            end else begin
              seq_idx     <= seq_idx + 8'd1;
              gen_seq_num <= seq_idx + 8'd1;
              gen_start   <= 1'b1;
              state       <= REQ;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_result_sequencer.sv
// Randomised bench for lfsr_result_sequencer: a generator model drives the
// DUT and a timetable model predicts every output on every cycle.
module tb_lfsr_result_sequencer;

  localparam int TIMEOUT = 16;
  localparam int HOLD    = 4;

  logic        clk;
  logic        rst_n;
  logic        go;
  logic [7:0]  last_seq;
  logic        gen_start;
  logic [7:0]  gen_seq_num;
  logic        gen_busy;
  logic [7:0]  gen_num;
  logic [7:0]  result;
  logic [11:0] bcd;
  logic        result_valid;
  logic        running;
  logic        timeout_err;

  lfsr_result_sequencer #(.TIMEOUT(TIMEOUT), .HOLD(HOLD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .go           (go),
    .last_seq     (last_seq),
    .gen_start    (gen_start),
    .gen_seq_num  (gen_seq_num),
    .gen_busy     (gen_busy),
    .gen_num      (gen_num),
    .result       (result),
    .bcd          (bcd),
    .result_valid (result_valid),
    .running      (running),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Generator model: busy rises the cycle after start, stays high gen_b
  // cycles, and the answer is on gen_num only on the first low cycle.
  // gen_b == 0 models a generator that never answers.
  int         gen_b = 1;
  logic [7:0] vals [256];
  int         busy_left;
  logic [7:0] gen_idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gen_busy  <= 1'b0;
      gen_num   <= 8'd0;
      busy_left <= 0;
      gen_idx   <= 8'd0;
    end else begin
      gen_num <= 8'($urandom);
      if (gen_start && gen_b > 0) begin
        gen_busy  <= 1'b1;
        busy_left <= gen_b;
        gen_idx   <= gen_seq_num;
      end else if (busy_left == 1) begin
        gen_busy  <= 1'b0;
        busy_left <= 0;
        gen_num   <= vals[gen_idx];
      end else if (busy_left > 1) begin
        busy_left <= busy_left - 1;
      end
    end
  end

  // Timetable model: an accepted go at cycle c puts request k at
  // c+1+k*(11+B+HOLD) and its result B+10 cycles after that request.
  typedef struct {
    int cyc;
    int val;
  } ev_t;

  ev_t         start_q[$];
  ev_t         valid_q[$];
  int          run_begin = 0;
  int          run_end   = 0;
  int          err_at    = -1;
  int          clr_at    = -1;
  bit          model_err = 1'b0;
  bit          prev_err  = 1'b0;
  logic [7:0]  last_res  = 8'd0;
  logic [11:0] last_bcd  = 12'd0;

  int          n_start = 0;
  int          n_valid = 0;
  int          err_rise_cyc = -1;
  int          start_cyc_q[$];
  logic [7:0]  obs_res_q[$];
  logic [11:0] obs_bcd_q[$];

  task automatic schedule(input int t0);
    ev_t e;
    int  p;
    int  last;
    p         = 11 + gen_b + HOLD;
    last      = int'(last_seq);
    run_begin = t0;
    clr_at    = t0;
    if (gen_b == 0) begin
      e.cyc = t0; e.val = 0; start_q.push_back(e);
      err_at  = t0 + 1 + TIMEOUT;
      run_end = err_at;
    end else begin
      for (int k = 0; k <= last; k++) begin
        e.cyc = t0 + k * p; e.val = k; start_q.push_back(e);
        e.cyc = t0 + k * p + gen_b + 10; e.val = int'(vals[k]); valid_q.push_back(e);
      end
      run_end = t0 + (last + 1) * p;
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs",
            {gen_start, result_valid, running, timeout_err, gen_seq_num, result, bcd}, 32'd0);
      start_q.delete();
      valid_q.delete();
      run_begin = 0;
      run_end   = 0;
      err_at    = -1;
      clr_at    = -1;
      model_err = 1'b0;
      prev_err  = 1'b0;
      last_res  = 8'd0;
      last_bcd  = 12'd0;
    end else begin
      bit exp_s;
      bit exp_v;
      if (cyc == clr_at) model_err = 1'b0;
      if (cyc == err_at) model_err = 1'b1;

      exp_s = (start_q.size() > 0) && (start_q[0].cyc == cyc);
      check("gen_start", 32'(gen_start), 32'(exp_s));
      if (exp_s) begin
        check("gen_seq_num", 32'(gen_seq_num), 32'(start_q[0].val));
        void'(start_q.pop_front());
      end
      if (gen_start) begin
        n_start++;
        start_cyc_q.push_back(cyc);
      end

      exp_v = (valid_q.size() > 0) && (valid_q[0].cyc == cyc);
      check("result_valid", 32'(result_valid), 32'(exp_v));
      if (exp_v) begin
        last_res = 8'(valid_q[0].val);
        last_bcd = to_bcd(valid_q[0].val);
        void'(valid_q.pop_front());
      end
      check("result", 32'(result), 32'(last_res));
      check("bcd", 32'(bcd), 32'(last_bcd));
      if (result_valid) begin
        n_valid++;
        obs_res_q.push_back(result);
        obs_bcd_q.push_back(bcd);
      end

      check("running", 32'(running), 32'(cyc >= run_begin && cyc < run_end));
      check("timeout_err", 32'(timeout_err), 32'(model_err));
      if (timeout_err && !prev_err) err_rise_cyc = cyc;
      prev_err = timeout_err;

      if (go && cyc >= run_end) schedule(cyc + 1);
    end
  end

  function automatic int start_cyc(input int i);
    return (start_cyc_q.size() > i) ? start_cyc_q[i] : -1000;
  endfunction

  function automatic logic [11:0] obs_bcd(input int i);
    return (obs_bcd_q.size() > i) ? obs_bcd_q[i] : 12'hfff;
  endfunction

  function automatic logic [7:0] obs_res(input int i);
    return (obs_res_q.size() > i) ? obs_res_q[i] : 8'hxx;
  endfunction

  task automatic clear_obs();
    n_start      = 0;
    n_valid      = 0;
    err_rise_cyc = -1;
    start_cyc_q.delete();
    obs_res_q.delete();
    obs_bcd_q.delete();
  endtask

  task automatic start_go(input int last);
    @(posedge clk); #1;
    last_seq = 8'(last);
    go       = 1'b1;
    @(posedge clk); #1;
    go       = 1'b0;
    last_seq = 8'($urandom);
  endtask

  // Runs until the model says the block is idle again; optional go noise
  // while running, and last_seq always scrambled after capture.
  task automatic finish_run(input bit noise);
    int guard;
    guard = 0;
    while (cyc < run_end && guard < 20000) begin
      go       = noise && (cyc < run_end - 1) && ($urandom_range(0, 3) == 0);
      last_seq = 8'($urandom);
      @(posedge clk); #1;
      guard++;
    end
    go = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [11:0] seq_bcd  [4] = '{12'h007, 12'h017, 12'h027, 12'h037};
  logic [11:0] edge_bcd [4] = '{12'h000, 12'h255, 12'h099, 12'h100};

  initial begin
    int last;
    rst_n    = 1'b1;
    go       = 1'b0;
    last_seq = 8'd0;
    for (int i = 0; i < 256; i++) vals[i] = 8'd0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request
    clear_obs();
    vals[0] = 8'd173;
    gen_b   = 5;
    start_go(0);
    finish_run(1'b0);
    check("single_starts", 32'(n_start), 32'd1);
    check("single_valids", 32'(n_valid), 32'd1);
    check("single_result", 32'(obs_res(0)), 32'd173);
    check("single_bcd", 32'(obs_bcd(0)), 32'h173);
    check("single_running", 32'(running), 32'd0);

    // Four-request sequence with fixed spacing
    clear_obs();
    for (int k = 0; k < 4; k++) vals[k] = 8'(10 * k + 7);
    gen_b = 2;
    start_go(3);
    finish_run(1'b0);
    for (int k = 0; k < 4; k++) check("seq_bcd", 32'(obs_bcd(k)), 32'(seq_bcd[k]));
    for (int k = 1; k < 4; k++)
      check("seq_spacing", 32'(start_cyc(k) - start_cyc(k - 1)), 32'(1 + 1 + 2 + 8 + 1 + HOLD));

    // BCD boundaries with go pulses during the run
    clear_obs();
    vals[0] = 8'd0; vals[1] = 8'd255; vals[2] = 8'd99; vals[3] = 8'd100;
    gen_b = 4;
    start_go(3);
    finish_run(1'b1);
    for (int k = 0; k < 4; k++) check("edge_bcd", 32'(obs_bcd(k)), 32'(edge_bcd[k]));
    check("edge_starts", 32'(n_start), 32'd4);

    // Generator never answers
    clear_obs();
    gen_b = 0;
    start_go(0);
    finish_run(1'b0);
    check("timeout_valids", 32'(n_valid), 32'd0);
    check("timeout_latency", 32'(err_rise_cyc - (start_cyc(0) + 1)), 32'(TIMEOUT));
    check("timeout_sticky", 32'(timeout_err), 32'd1);

    // Next go clears the error
    clear_obs();
    vals[0] = 8'd42;
    gen_b   = 1;
    start_go(0);
    finish_run(1'b0);
    check("err_cleared", 32'(timeout_err), 32'd0);
    check("after_err_result", 32'(obs_res(0)), 32'd42);

    // Reset in the middle of the conversion of 200
    clear_obs();
    vals[0] = 8'd200;
    gen_b   = 3;
    start_go(0);
    repeat (3 + 5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_result", 32'(result), 32'd0);
    check("abort_bcd", 32'(bcd), 32'd0);
    check("abort_running", 32'(running), 32'd0);
    check("abort_valids", 32'(n_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    go       = 1'b1;
    last_seq = 8'd0;
    @(posedge clk); #1;
    go = 1'b0;
    finish_run(1'b0);
    check("rerun_starts", 32'(n_start), 32'd2);
    check("rerun_valids", 32'(n_valid), 32'd1);
    check("rerun_bcd", 32'(obs_bcd(0)), 32'h200);

    // Random runs with noise on go and last_seq
    for (int r = 0; r < 6; r++) begin
      clear_obs();
      last  = $urandom_range(0, 12);
      gen_b = $urandom_range(1, 6);
      for (int k = 0; k < 256; k++) vals[k] = 8'($urandom);
      start_go(last);
      finish_run(1'b1);
      check("rand_starts", 32'(n_start), 32'(last + 1));
      check("rand_valids", 32'(n_valid), 32'(last + 1));
    end

    // Full 256-request run covering every BCD input
    clear_obs();
    for (int k = 0; k < 256; k++) vals[k] = 8'(k);
    gen_b = 1;
    start_go(255);
    finish_run(1'b1);
    check("full_starts", 32'(n_start), 32'd256);
    check("full_valids", 32'(n_valid), 32'd256);
    check("full_bcd_99", 32'(obs_bcd(99)), 32'h099);
    check("full_bcd_255", 32'(obs_bcd(255)), 32'h255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
